rst_seq_ctrl_25m: RTL and testbench
===================================

// Module: rst_seq_ctrl_25m
// PURPOSE
//  Staged reset sequencer in the 25 MHz domain, fed by the synchronised 25 MHz reset.
//  Releases PMA, PCS and MAC resets in order once the PHY PLL has been locked long enough.
//  Re-enters hold on PLL lock loss or a soft-reset request.
//  Reports init_done and counts lock-loss events.
// PARAMETERS
//  LOCK_STABLE_CYC  256  consecutive synced-lock cycles required before PMA release (>=2)
//  PMA_HOLD_CYC     64   cycles all resets are held after lock loss or soft reset (>=1)
//  PCS_DELAY_CYC    32   cycles from PMA release to PCS release (>=1)
//  MAC_DELAY_CYC    16   cycles from PCS release to MAC release (>=1)
//  CNT_W            16   delay counter width; must hold max(parameters)-1
// PORTS
//  sys_clk_25m    in   1  clock, 25 MHz
//  reset_n        in   1  reset, asynchronous, active-low
//  pll_locked     in   1  PHY PLL lock, asynchronous to sys_clk_25m
//  soft_rst_req   in   1  one-cycle pulse, synchronous to sys_clk_25m
//  pma_rst_n      out  1  PMA reset, active-low, registered
//  pcs_rst_n      out  1  PCS reset, active-low, registered
//  mac_rst_n      out  1  MAC reset, active-low, registered
//  init_done      out  1  high only in RUN, registered
//  lock_loss      out  1  one-cycle pulse per detected lock loss
//  lock_loss_cnt  out  8  saturating count of lock-loss events (stops at 8'hFF)
//  seq_state      out  3  current state encoding, for debug/status
// BEHAVIOUR
//  Reset values: all *_rst_n = 0, init_done = 0, lock_loss = 0, lock_loss_cnt = 0, state = WAIT_LOCK, counter = 0.
//  pll_locked passes through a 2-FF synchroniser; the synchronised value is lock_s, 2 edges of latency.
//  States and encodings:
//    WAIT_LOCK = 0, REL_PMA = 1, REL_PCS = 2, RUN = 3, HOLD = 4.
//  WAIT_LOCK:
//    All resets low.
//    Counter increments while lock_s = 1 and clears when lock_s = 0.
//    At count == LOCK_STABLE_CYC-1 with lock_s = 1, go to REL_PMA and clear the counter.
//  REL_PMA:
//    pma_rst_n = 1.
//    After PCS_DELAY_CYC cycles, go to REL_PCS.
//  REL_PCS:
//    pma_rst_n = 1, pcs_rst_n = 1.
//    After MAC_DELAY_CYC cycles, go to RUN.
//  RUN:
//    All three resets = 1, init_done = 1.
//  HOLD:
//    All resets low.
//    After PMA_HOLD_CYC cycles, go to WAIT_LOCK.
//  Lock loss (lock_s = 0 in REL_PMA, REL_PCS or RUN):
//    Next edge: state = HOLD, all resets low, init_done low, counter cleared.
//    lock_loss pulses for exactly that cycle; lock_loss_cnt increments by 1, saturating.
//    Net latency from the pll_locked fall to the resets falling is 3 edges.
//  soft_rst_req in any state:
//    Go to HOLD with the counter cleared; no lock_loss pulse.
//    In HOLD it restarts the hold count.
//  Simultaneous lock loss and soft_rst_req: the lock-loss path wins (pulse and count increment both occur).
//  Lock glitches shorter than the 2-FF window may be missed; this is accepted.
//  Reset assertion mid-sequence: all outputs return to their reset values asynchronously.
//  Outputs are decoded from the registered next-state; no combinational path from input to output.
// STRUCTURE
//  Package rst_seq_pkg: state localparams (3-bit) and SEQ_STATE_W = 3.
//  Sub-module sync_2ff: 1-bit, 2-flop synchroniser, async active-low clear to 0. Used for pll_locked.
//  Remainder: one FSM, one CNT_W delay counter, one 8-bit saturating event counter.
// TESTING
//  1. Default parameters; release reset_n, pll_locked held 1:
//     - pma_rst_n rises after edge 258;
//     - pcs_rst_n rises after edge 290;
//     - mac_rst_n and init_done rise after edge 306.
//  2. pll_locked toggles low for 10 cycles at count 200 in WAIT_LOCK:
//     - counter restarts;
//     - pma release is delayed by the full 256 stable cycles after the toggle.
//  3. In RUN, drop pll_locked:
//     - all resets fall 3 edges later;
//     - lock_loss = 1 for one cycle; lock_loss_cnt = 1;
//     - with pll_locked restored, the full sequence re-runs after 64 hold cycles.
//  4. soft_rst_req in RUN: HOLD with no lock_loss pulse. A second soft_rst_req 30 cycles into HOLD extends HOLD to 94 cycles total.
//  5. Lock loss coincident with soft_rst_req: a single lock_loss pulse and cnt +1. Apply 300 lock losses: cnt saturates at 255.
//  6. Assert reset_n mid-REL_PCS: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the 25 MHz staged reset sequencer.
//   SEQ_STATE_W : width of the sequencer state encoding
//   seq_state_e : sequencer states, encodings visible on the debug port
//   sat_inc8    : 8-bit saturating increment used by the lock-loss counter
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    localparam int SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_REL_PMA   = 3'd1,
        ST_REL_PCS   = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } seq_state_e;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [7:0] sat_inc8(input logic [7:0] i_val);
        logic [7:0] w_res;
        if (i_val == 8'hFF) begin
            w_res = i_val;
        end else begin
            w_res = i_val + 8'd1;
        end
        return w_res;
    endfunction

endpackage

// File: rtl/rst_seq_ctrl_25m_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level, cleared to 0 by reset.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low clear
//   i_d     : asynchronous input level
//   o_q     : synchronised level, two destination edges of latency
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Metastability filter: first flop may go metastable, second resolves it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rst_seq_ctrl_25m.sv
// -----------------------------------------------------------------------------
// rst_seq_ctrl_25m
// Staged reset sequencer in the 25 MHz domain. Waits for a stable PHY PLL lock,
// then releases PMA, PCS and MAC resets in order. Lock loss or a soft-reset
// request drops every reset and holds them for a fixed time before retrying.
//   sys_clk_25m   : 25 MHz clock
//   reset_n       : asynchronous active-low reset
//   pll_locked    : PHY PLL lock, asynchronous
//   soft_rst_req  : one-cycle soft-reset request, synchronous
//   pma_rst_n     : PMA reset, active-low
//   pcs_rst_n     : PCS reset, active-low
//   mac_rst_n     : MAC reset, active-low
//   init_done     : high only while fully out of reset (RUN)
//   lock_loss     : one-cycle pulse per detected lock loss
//   lock_loss_cnt : saturating count of lock losses
//   seq_state     : current state encoding
// All outputs are registered and decoded from the next state.
// -----------------------------------------------------------------------------
module rst_seq_ctrl_25m
    import rst_seq_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYC = 32'd256,
    parameter int unsigned PMA_HOLD_CYC    = 32'd64,
    parameter int unsigned PCS_DELAY_CYC   = 32'd32,
    parameter int unsigned MAC_DELAY_CYC   = 32'd16,
    parameter int unsigned CNT_W           = 32'd16
) (
    input  logic                   sys_clk_25m,
    input  logic                   reset_n,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic                   pma_rst_n,
    output logic                   pcs_rst_n,
    output logic                   mac_rst_n,
    output logic                   init_done,
    output logic                   lock_loss,
    output logic [7:0]             lock_loss_cnt,
    output logic [SEQ_STATE_W-1:0] seq_state
);

    // Terminal counts: a stage lasting N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PMA_HOLD_CYC - 32'd1);
    localparam logic [CNT_W-1:0] PCS_LAST  = CNT_W'(PCS_DELAY_CYC - 32'd1);
    localparam logic [CNT_W-1:0] MAC_LAST  = CNT_W'(MAC_DELAY_CYC - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic            w_lock_s;
    seq_state_e      r_state;
    seq_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic            w_lock_lost;
    logic            w_lock_loss_nxt;
    logic            w_pma_nxt;
    logic            w_pcs_nxt;
    logic            w_mac_nxt;
    logic            w_init_nxt;
    logic            r_pma_rst_n;
    logic            r_pcs_rst_n;
    logic            r_mac_rst_n;
    logic            r_init_done;
    logic            r_lock_loss;
    logic [7:0]      r_lock_loss_cnt;

    sync_2ff u_lock_sync (
        .i_clk   (sys_clk_25m),
        .i_rst_n (reset_n),
        .i_d     (pll_locked),
        .o_q     (w_lock_s)
    );

    // Lock loss only counts once the PMA has been released.
    always_comb begin
        w_lock_lost = 1'b0;
        case (r_state)
            ST_REL_PMA, ST_REL_PCS, ST_RUN: w_lock_lost = ~w_lock_s;
            default:                        w_lock_lost = 1'b0;
        endcase
    end

    // Next-state and delay-counter logic; lock loss outranks soft reset.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lock_loss_nxt = 1'b0;
        if (w_lock_lost) begin
            w_state_nxt     = ST_HOLD;
            w_cnt_nxt       = CNT_ZERO;
            w_lock_loss_nxt = 1'b1;
        end else if (soft_rst_req) begin
            // Also restarts the hold count when already in HOLD.
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = CNT_ZERO;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (!w_lock_s) begin
                        w_cnt_nxt = CNT_ZERO;
                    end else if (r_cnt == LOCK_LAST) begin
                        w_state_nxt = ST_REL_PMA;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_REL_PMA: begin
                    if (r_cnt == PCS_LAST) begin
                        w_state_nxt = ST_REL_PCS;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_REL_PCS: begin
                    if (r_cnt == MAC_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    w_cnt_nxt = CNT_ZERO;
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = CNT_ZERO;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = CNT_ZERO;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs change on the same edge as the state.
    always_comb begin
        w_pma_nxt  = 1'b0;
        w_pcs_nxt  = 1'b0;
        w_mac_nxt  = 1'b0;
        w_init_nxt = 1'b0;
        case (w_state_nxt)
            ST_REL_PMA: begin
                w_pma_nxt = 1'b1;
            end
            ST_REL_PCS: begin
                w_pma_nxt = 1'b1;
                w_pcs_nxt = 1'b1;
            end
            ST_RUN: begin
                w_pma_nxt  = 1'b1;
                w_pcs_nxt  = 1'b1;
                w_mac_nxt  = 1'b1;
                w_init_nxt = 1'b1;
            end
            default: begin
                w_pma_nxt  = 1'b0;
                w_pcs_nxt  = 1'b0;
                w_mac_nxt  = 1'b0;
                w_init_nxt = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge sys_clk_25m or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_WAIT_LOCK;
            r_cnt           <= CNT_ZERO;
            r_pma_rst_n     <= 1'b0;
            r_pcs_rst_n     <= 1'b0;
            r_mac_rst_n     <= 1'b0;
            r_init_done     <= 1'b0;
            r_lock_loss     <= 1'b0;
            r_lock_loss_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pma_rst_n <= w_pma_nxt;
            r_pcs_rst_n <= w_pcs_nxt;
            r_mac_rst_n <= w_mac_nxt;
            r_init_done <= w_init_nxt;
            r_lock_loss <= w_lock_loss_nxt;
            if (w_lock_loss_nxt) begin
                r_lock_loss_cnt <= sat_inc8(r_lock_loss_cnt);
            end else begin
                r_lock_loss_cnt <= r_lock_loss_cnt;
            end
        end
    end

    assign pma_rst_n     = r_pma_rst_n;
    assign pcs_rst_n     = r_pcs_rst_n;
    assign mac_rst_n     = r_mac_rst_n;
    assign init_done     = r_init_done;
    assign lock_loss     = r_lock_loss;
    assign lock_loss_cnt = r_lock_loss_cnt;
    assign seq_state     = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl_25m.sv
// -----------------------------------------------------------------------------
// tb_rst_seq_ctrl_25m
// Self-checking bench for rst_seq_ctrl_25m. A default-parameter instance walks
// the full release sequence, lock loss, soft reset, lock glitch, coincident
// events and asynchronous reset. A short-delay instance exercises saturation
// of the lock-loss counter. Expected values go through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_rst_seq_ctrl_25m;

    logic       sys_clk_25m = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       pma_rst_n, pcs_rst_n, mac_rst_n, init_done, lock_loss;
    logic [7:0] lock_loss_cnt;
    logic [2:0] seq_state;

    logic       pll_s;
    logic       soft_s;
    logic       pma_s, pcs_s, mac_s, init_s, ll_s;
    logic [7:0] cnt_s;
    logic [2:0] st_s;

    int n_checks = 0;
    int n_pass   = 0;
    int edge_cnt = 0;

    always #20 sys_clk_25m = ~sys_clk_25m;

    always @(posedge sys_clk_25m) edge_cnt <= edge_cnt + 1;

    rst_seq_ctrl_25m u_dut (
        .sys_clk_25m   (sys_clk_25m),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .soft_rst_req  (soft_rst_req),
        .pma_rst_n     (pma_rst_n),
        .pcs_rst_n     (pcs_rst_n),
        .mac_rst_n     (mac_rst_n),
        .init_done     (init_done),
        .lock_loss     (lock_loss),
        .lock_loss_cnt (lock_loss_cnt),
        .seq_state     (seq_state)
    );

    rst_seq_ctrl_25m #(
        .LOCK_STABLE_CYC (32'd2),
        .PMA_HOLD_CYC    (32'd1),
        .PCS_DELAY_CYC   (32'd1),
        .MAC_DELAY_CYC   (32'd1),
        .CNT_W           (32'd4)
    ) u_dut_s (
        .sys_clk_25m   (sys_clk_25m),
        .reset_n       (reset_n),
        .pll_locked    (pll_s),
        .soft_rst_req  (soft_s),
        .pma_rst_n     (pma_s),
        .pcs_rst_n     (pcs_s),
        .mac_rst_n     (mac_s),
        .init_done     (init_s),
        .lock_loss     (ll_s),
        .lock_loss_cnt (cnt_s),
        .seq_state     (st_s)
    );

    logic [15:0] main_vec;
    logic [15:0] small_vec;
    assign main_vec  = {pma_rst_n, pcs_rst_n, mac_rst_n, init_done, lock_loss, lock_loss_cnt, seq_state};
    assign small_vec = {pma_s, pcs_s, mac_s, init_s, ll_s, cnt_s, st_s};

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    typedef struct {
        int          off;
        logic [2:0]  st;
        string       name;
    } vec_t;

    sb_t  sb_q[$];
    vec_t t1[10];

    // Expected output vector for a given state; reset levels follow the state.
    function automatic logic [15:0] model(input logic [2:0] st, input logic ll, input logic [7:0] cnt);
        logic pma, pcs, mac, ini;
        pma = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
        pcs = (st == 3'd2) || (st == 3'd3);
        mac = (st == 3'd3);
        ini = (st == 3'd3);
        return {pma, pcs, mac, ini, ll, cnt, st};
    endfunction

    task automatic push(input string nm, input logic [15:0] e);
        sb_t r;
        r.name = nm;
        r.exp  = e;
        sb_q.push_back(r);
    endtask

    task automatic pop_cmp(input logic [15:0] act);
        sb_t r;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard_empty: got %h expected <entry>", act);
        end else begin
            r = sb_q.pop_front();
            if (act === r.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s @edge %0d: got %h expected %h (pma pcs mac init ll cnt[8] st[3])",
                         r.name, edge_cnt, act, r.exp);
            end
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        $display("FAIL %s: timeout, got no event expected event", nm);
    endtask

    task automatic goto_edge(input int tgt);
        while (edge_cnt < tgt) begin
            @(posedge sys_clk_25m);
            #1;
        end
    endtask

    task automatic expect_at(input int tgt, input logic [2:0] st, input logic ll,
                             input logic [7:0] cnt, input string nm);
        push(nm, model(st, ll, cnt));
        goto_edge(tgt);
        pop_cmp(main_vec);
    endtask

    initial begin
        #(40 * 25000);
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, l, h, s, w, k;
        logic [7:0] exp_cnt;

        t1[0] = '{0,   3'd0, "t1_release"};
        t1[1] = '{2,   3'd0, "t1_sync"};
        t1[2] = '{257, 3'd0, "t1_pre_pma"};
        t1[3] = '{258, 3'd1, "t1_pma"};
        t1[4] = '{289, 3'd1, "t1_pre_pcs"};
        t1[5] = '{290, 3'd2, "t1_pcs"};
        t1[6] = '{305, 3'd2, "t1_pre_mac"};
        t1[7] = '{306, 3'd3, "t1_mac"};
        t1[8] = '{320, 3'd3, "t1_run"};
        t1[9] = '{321, 3'd3, "t1_run2"};

        reset_n      = 1'b0;
        pll_locked   = 1'b1;
        soft_rst_req = 1'b0;
        pll_s        = 1'b1;
        soft_s       = 1'b0;
        repeat (3) @(posedge sys_clk_25m);
        #1;
        push("reset_main", model(3'd0, 1'b0, 8'd0));
        pop_cmp(main_vec);
        push("reset_small", model(3'd0, 1'b0, 8'd0));
        pop_cmp(small_vec);

        // 1: nominal release sequence
        @(negedge sys_clk_25m);
        reset_n = 1'b1;
        base = edge_cnt;
        for (int i = 0; i < 10; i++) begin
            expect_at(base + t1[i].off, t1[i].st, 1'b0, 8'd0, t1[i].name);
        end

        // 3: lock loss in RUN, then full re-run after hold
        l = edge_cnt;
        @(negedge sys_clk_25m);
        pll_locked = 1'b0;
        expect_at(l + 2, 3'd3, 1'b0, 8'd0, "ll_latency");
        expect_at(l + 3, 3'd4, 1'b1, 8'd1, "ll_pulse");
        @(negedge sys_clk_25m);
        pll_locked = 1'b1;
        expect_at(l + 4, 3'd4, 1'b0, 8'd1, "ll_single");
        h = l + 3;
        expect_at(h + 63,  3'd4, 1'b0, 8'd1, "hold_end");
        expect_at(h + 64,  3'd0, 1'b0, 8'd1, "hold_exit");
        expect_at(h + 319, 3'd0, 1'b0, 8'd1, "rerun_pre_pma");
        expect_at(h + 320, 3'd1, 1'b0, 8'd1, "rerun_pma");
        expect_at(h + 352, 3'd2, 1'b0, 8'd1, "rerun_pcs");
        expect_at(h + 368, 3'd3, 1'b0, 8'd1, "rerun_run");

        // 4: soft reset in RUN, second request extends HOLD
        @(negedge sys_clk_25m);
        soft_rst_req = 1'b1;
        s = edge_cnt + 1;
        expect_at(s, 3'd4, 1'b0, 8'd1, "soft_hold");
        @(negedge sys_clk_25m);
        soft_rst_req = 1'b0;
        goto_edge(s + 29);
        @(negedge sys_clk_25m);
        soft_rst_req = 1'b1;
        expect_at(s + 30, 3'd4, 1'b0, 8'd1, "soft2_hold");
        @(negedge sys_clk_25m);
        soft_rst_req = 1'b0;
        expect_at(s + 64, 3'd4, 1'b0, 8'd1, "hold_extended");
        expect_at(s + 93, 3'd4, 1'b0, 8'd1, "hold_ext_end");
        expect_at(s + 94, 3'd0, 1'b0, 8'd1, "hold_ext_exit");

        // 2: lock glitch at count 200 in WAIT_LOCK restarts the stability count
        w = s + 94;
        goto_edge(w + 200);
        @(negedge sys_clk_25m);
        pll_locked = 1'b0;
        goto_edge(w + 210);
        @(negedge sys_clk_25m);
        pll_locked = 1'b1;
        expect_at(w + 256, 3'd0, 1'b0, 8'd1, "glitch_no_early");
        expect_at(w + 467, 3'd0, 1'b0, 8'd1, "glitch_pre_pma");
        expect_at(w + 468, 3'd1, 1'b0, 8'd1, "glitch_pma");
        expect_at(w + 516, 3'd3, 1'b0, 8'd1, "glitch_run");

        // 5a: lock loss coincident with soft reset
        l = edge_cnt;
        @(negedge sys_clk_25m);
        pll_locked = 1'b0;
        goto_edge(l + 2);
        @(negedge sys_clk_25m);
        soft_rst_req = 1'b1;
        expect_at(l + 3, 3'd4, 1'b1, 8'd2, "coinc_pulse");
        @(negedge sys_clk_25m);
        soft_rst_req = 1'b0;
        pll_locked   = 1'b1;
        expect_at(l + 4, 3'd4, 1'b0, 8'd2, "coinc_single");

        // 6: asynchronous reset mid-REL_PCS
        h = l + 3;
        expect_at(h + 352, 3'd2, 1'b0, 8'd2, "pcs_again");
        goto_edge(h + 360);
        #5;
        reset_n = 1'b0;
        #1;
        push("async_rst_main", model(3'd0, 1'b0, 8'd0));
        pop_cmp(main_vec);

        // 5b: saturation of the lock-loss counter on the short-delay instance
        @(negedge sys_clk_25m);
        reset_n = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            k = 0;
            while (st_s !== 3'd3 && k < 50) begin
                @(posedge sys_clk_25m);
                #1;
                k++;
            end
            if (k >= 50) begin
                timeout("sat_wait_run");
                break;
            end
            @(negedge sys_clk_25m);
            pll_s = 1'b0;
            k = 0;
            while (ll_s !== 1'b1 && k < 10) begin
                @(posedge sys_clk_25m);
                #1;
                k++;
            end
            exp_cnt = (i > 255) ? 8'd255 : 8'(i);
            if (k >= 10) begin
                timeout("sat_wait_pulse");
                break;
            end
            push($sformatf("sat_cnt_%0d", i), model(3'd4, 1'b1, exp_cnt));
            pop_cmp(small_vec);
            @(negedge sys_clk_25m);
            pll_s = 1'b1;
        end
        repeat (3) @(posedge sys_clk_25m);
        #1;
        push("sat_hold", {1'b0, 8'd255});
        pop_cmp({ll_s, cnt_s});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
